// File: rtl/mips_defs.sv
// Shared MIPS definitions for the HI/LO divide unit.
// Contents: the funct codes of the HI/LO instructions, the divider state
// encoding and the fixed divide latency in cycles.
package mips_defs;

  localparam logic [5:0] DIVU = 6'd27;
  localparam logic [5:0] MFHI = 6'd16;
  localparam logic [5:0] MTHI = 6'd17;
  localparam logic [5:0] MFLO = 6'd18;
  localparam logic [5:0] MTLO = 6'd19;

  localparam logic [0:0] DIV_STATE_IDLE = 1'b0;
  localparam logic [0:0] DIV_STATE_RUN  = 1'b1;

  localparam int unsigned DIV_LATENCY = 32;

endpackage

// File: rtl/divu_step.sv
// One restoring-division step, purely combinational.
// Ports: r (partial remainder), q (quotient/dividend shift register) and
// d (divisor) in; r_next and q_next (state after one quotient bit) out.
module divu_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] d_ext;
  logic           fits;

  assign shifted = {r, q[WIDTH-1]};
  assign d_ext   = {1'b0, d};
  assign fits    = (shifted >= d_ext);

  // A non-negative difference is always below d, so it fits in WIDTH bits.
  assign r_next = fits ? WIDTH'(shifted - d_ext) : shifted[WIDTH-1:0];
  assign q_next = {q[WIDTH-2:0], fits};

endmodule

// File: rtl/divu_hilo_unit.sv
// Multi-cycle unsigned divider with the HI/LO register pair.
// Ports: clk, rst (synchronous, active-high); start, dividend and divisor
// issue a DIVU; mthi, mtlo and wdata write HI/LO directly. hi (remainder) and
// lo (quotient) are read directly. Hi_Lo is high while the unit is idle and
// its results are valid; busy is its registered complement.
module divu_hilo_unit
  import mips_defs::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             Hi_Lo,
  output logic             busy
);

  localparam int unsigned CNT_W = 6;

  logic [0:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] d_reg, d_nxt;
  logic [WIDTH-1:0] r_reg, r_nxt;
  logic [WIDTH-1:0] q_reg, q_nxt;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic             hi_lo_nxt, busy_nxt;
  logic [WIDTH-1:0] step_r, step_q;

  divu_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_reg),
    .q      (q_reg),
    .d      (d_reg),
    .r_next (step_r),
    .q_next (step_q)
  );

  // Next-state and datapath update.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    d_nxt     = d_reg;
    r_nxt     = r_reg;
    q_nxt     = q_reg;
    hi_nxt    = hi;
    lo_nxt    = lo;
    hi_lo_nxt = Hi_Lo;
    busy_nxt  = busy;
    case (state)
      DIV_STATE_IDLE: begin
        if (start) begin
          // start takes priority; any concurrent MTHI/MTLO is dropped
          state_nxt = DIV_STATE_RUN;
          d_nxt     = divisor;
          r_nxt     = '0;
          q_nxt     = dividend;
          cnt_nxt   = '0;
          hi_lo_nxt = 1'b0;
          busy_nxt  = 1'b1;
        end else begin
          if (mthi) hi_nxt = wdata;
          if (mtlo) lo_nxt = wdata;
        end
      end
      DIV_STATE_RUN: begin
        r_nxt   = step_r;
        q_nxt   = step_q;
        cnt_nxt = cnt + CNT_W'(1);
        // Results go straight to HI/LO on the last step so they appear
        // together with Hi_Lo rising.
        if (cnt == CNT_W'(WIDTH - 1)) begin
          state_nxt = DIV_STATE_IDLE;
          hi_nxt    = step_r;
          lo_nxt    = step_q;
          hi_lo_nxt = 1'b1;
          busy_nxt  = 1'b0;
        end
      end
      default: state_nxt = DIV_STATE_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DIV_STATE_IDLE;
      cnt   <= '0;
      d_reg <= '0;
      r_reg <= '0;
      q_reg <= '0;
      hi    <= '0;
      lo    <= '0;
      Hi_Lo <= 1'b1;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      d_reg <= d_nxt;
      r_reg <= r_nxt;
      q_reg <= q_nxt;
      hi    <= hi_nxt;
      lo    <= lo_nxt;
      Hi_Lo <= hi_lo_nxt;
      busy  <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_divu_hilo_unit.sv
// Directed bench for divu_hilo_unit: divide results, fixed latency,
// ignored start/MTHI during a divide, MTHI/MTLO writes and mid-divide reset.
module tb_divu_hilo_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        Hi_Lo;
  logic        busy;

  int passed;
  int total;

  divu_hilo_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .mthi     (mthi),
    .mtlo     (mtlo),
    .wdata    (wdata),
    .hi       (hi),
    .lo       (lo),
    .Hi_Lo    (Hi_Lo),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle; inputs changed after this hit the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Issue a divide, then count edges until Hi_Lo returns high (bounded).
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int n;
    start = 1'b1; dividend = a; divisor = b;
    tick();
    start = 1'b0;
    chk({tag, "_hilo_low"}, 32'(Hi_Lo), 32'd0);
    n = 0;
    while (Hi_Lo == 1'b0 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd32);
    chk({tag, "_lo"}, lo, exp_lo);
    chk({tag, "_hi"}, hi, exp_hi);
  endtask

  initial begin
    passed = 0; total = 0;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_hilo", 32'(Hi_Lo), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);

    run_div("d100_7", 32'd100, 32'd7, 32'd14, 32'd2);
    chk("d100_7_busy_done", 32'(busy), 32'd0);
    run_div("dmax_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
    run_div("d10_20", 32'h10, 32'h20, 32'd0, 32'h10);
    run_div("div0", 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_04D2);

    // Second start at cycle 5 and MTHI at cycle 10 must both be ignored.
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    tick();
    start = 1'b0;
    chk("ign_busy", 32'(busy), 32'd1);
    repeat (4) tick();
    start = 1'b1; dividend = 32'd9; divisor = 32'd3;
    tick();
    start = 1'b0;
    repeat (4) tick();
    mthi = 1'b1; wdata = 32'h0000_AAAA;
    tick();
    mthi = 1'b0;
    chk("ign_hi_held", hi, 32'h0000_04D2);
    chk("ign_lo_held", lo, 32'hFFFF_FFFF);
    begin
      int n;
      n = 0;
      while (Hi_Lo == 1'b0 && n < 40) begin
        tick();
        n++;
      end
      chk("ign_latency", 32'(n), 32'd22);
    end
    chk("ign_lo", lo, 32'd14);
    chk("ign_hi", hi, 32'd2);

    // MTHI / MTLO in IDLE, one-cycle latency.
    mthi = 1'b1; wdata = 32'h0000_1234;
    tick();
    mthi = 1'b0;
    chk("mthi_hi", hi, 32'h0000_1234);
    chk("mthi_lo_kept", lo, 32'd14);
    mtlo = 1'b1; wdata = 32'h0000_5678;
    tick();
    mtlo = 1'b0;
    chk("mtlo_lo", lo, 32'h0000_5678);
    chk("mtlo_hi_kept", hi, 32'h0000_1234);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0000_9999;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    chk("mtboth_hi", hi, 32'h0000_9999);
    chk("mtboth_lo", lo, 32'h0000_9999);

    // start together with MTHI: start wins, strobe dropped.
    mthi = 1'b1; wdata = 32'h0000_DEAD;
    run_div("start_wins", 32'd9, 32'd3, 32'd3, 32'd0);
    mthi = 1'b0;

    // Reset in the middle of a divide.
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    tick();
    start = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_hi", hi, 32'd0);
    chk("mid_rst_lo", lo, 32'd0);
    chk("mid_rst_hilo", 32'(Hi_Lo), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    tick();
    chk("mid_rst_stays_idle", 32'(Hi_Lo), 32'd1);

    run_div("after_rst", 32'd9, 32'd3, 32'd3, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
